// File: rtl/led_mode_pkg.sv
// Shared mode encoding for the board-UI LED mode controller.
// The two-bit mode value is also the encoding driven onto the mode output.
package led_mode_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_BLINK   = 2'd0;
  localparam logic [MODE_W-1:0] MODE_WALK_L  = 2'd1;
  localparam logic [MODE_W-1:0] MODE_WALK_R  = 2'd2;
  localparam logic [MODE_W-1:0] MODE_BREATHE = 2'd3;

endpackage

// File: rtl/key_debounce.sv
// One push-button: two-flop synchroniser, then a counter that accepts a new level only
// after DEBOUNCE_CYCLES consecutive samples that differ from the current debounced level.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 8192
) (
  input  logic clk_50m,
  input  logic rst,
  input  logic key_raw,
  output logic level,
  output logic pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    pulse_d = 1'b0;
    if (s2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = s2_q;
        pulse_d = s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= key_raw;
      s2_q    <= s1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign pulse = pulse_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// Board-UI LED controller: debounced keys step through four LED modes, and a free-running
// prescaler paces the blink/walk patterns and the breathe PWM.
module led_mode_ctrl
  import led_mode_pkg::*;
#(
  parameter int NUM_KEYS        = 2,
  parameter int NUM_LEDS        = 4,
  parameter int DEBOUNCE_CYCLES = 8192,
  parameter int STEP_BITS       = 26,
  parameter int PWM_BITS        = 8
) (
  input  logic                clk_50m,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key,
  output logic [NUM_LEDS-1:0] led,
  output logic [MODE_W-1:0]   mode,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_pulse
);

  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_50m(clk_50m),
      .rst    (rst),
      .key_raw(key[g]),
      .level  (key_level[g]),
      .pulse  (key_pulse[g])
    );
  end

  logic [STEP_BITS-1:0] prescaler_q;
  logic [MODE_W-1:0]    mode_q, mode_d;
  logic [NUM_LEDS-1:0]  led_q, led_d;
  logic [PWM_BITS-1:0]  duty_q, duty_d;
  logic                 dir_down_q, dir_down_d;
  logic                 reload;

  logic                step_tick, fine_tick;
  logic [PWM_BITS-1:0] pwm_cnt;

  assign step_tick = &prescaler_q;
  assign fine_tick = &prescaler_q[STEP_BITS-PWM_BITS-1:0];
  assign pwm_cnt   = prescaler_q[PWM_BITS-1:0];

  // Simultaneous next/previous presses cancel out and do not count as a mode entry.
  always_comb begin
    mode_d = mode_q;
    reload = 1'b0;
    case ({key_pulse[1], key_pulse[0]})
      2'b01: begin
        mode_d = mode_q + MODE_W'(1);
        reload = 1'b1;
      end
      2'b10: begin
        mode_d = mode_q - MODE_W'(1);
        reload = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    led_d      = led_q;
    duty_d     = duty_q;
    dir_down_d = dir_down_q;
    if (reload) begin
      case (mode_d)
        MODE_BLINK:  led_d = '1;
        MODE_WALK_L: led_d = NUM_LEDS'(1);
        MODE_WALK_R: led_d = {1'b1, {(NUM_LEDS-1){1'b0}}};
        default: begin
          led_d      = '0;
          duty_d     = '0;
          dir_down_d = 1'b0;
        end
      endcase
    end else begin
      case (mode_q)
        MODE_BLINK:  if (step_tick) led_d = ~led_q;
        MODE_WALK_L: if (step_tick) led_d = {led_q[NUM_LEDS-2:0], led_q[NUM_LEDS-1]};
        MODE_WALK_R: if (step_tick) led_d = {led_q[0], led_q[NUM_LEDS-1:1]};
        default: begin
          led_d = {NUM_LEDS{pwm_cnt < duty_q}};
          // The ramp dwells one fine tick at each end while the direction turns.
          if (fine_tick) begin
            if (!dir_down_q) begin
              if (duty_q == DUTY_MAX) dir_down_d = 1'b1;
              else                    duty_d     = duty_q + PWM_BITS'(1);
            end else begin
              if (duty_q == '0) dir_down_d = 1'b0;
              else              duty_d     = duty_q - PWM_BITS'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      prescaler_q <= '0;
      mode_q      <= MODE_BLINK;
      led_q       <= '0;
      duty_q      <= '0;
      dir_down_q  <= 1'b0;
    end else begin
      prescaler_q <= prescaler_q + STEP_BITS'(1);
      mode_q      <= mode_d;
      led_q       <= led_d;
      duty_q      <= duty_d;
      dir_down_q  <= dir_down_d;
    end
  end

  assign led  = led_q;
  assign mode = mode_q;

endmodule
